// File: rtl/crypto_round_sequencer.sv
// Control sequencer for the round-based crypto core: walks the encrypt or
// decrypt round schedule and emits one-hot datapath strobes with a start/ready/done handshake.
//
// state     | meaning
// IDLE      | waiting for start, ready=1
// LOAD      | load input block into state register
// ENC_XOR0  | initial key whitening, encrypt (round=0)
// ENC_SUB   | encrypt S-box
// ENC_SHIFT | encrypt row shift
// ENC_MIX   | encrypt mix-column (skipped in final round)
// ENC_KEY   | encrypt round key add, round+1
// DEC_XOR0  | initial key whitening, decrypt (round=NUM_ROUNDS)
// DEC_SHIFT | decrypt inverse row shift
// DEC_SUB   | decrypt inverse S-box
// DEC_KEY   | decrypt round key add, round-1
// DEC_MIX   | decrypt inverse mix-column
// OUT_DATA  | drive result onto output bus
// OUT_KEY   | drive final key onto output bus
// FIN       | done pulse
// ERR       | invalid mode, err pulse
module crypto_round_sequencer #(
  parameter int NUM_ROUNDS = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             stall,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] round,
  output logic [15:0]      ctrl
);

  // State codes equal the ctrl bit they drive; IDLE takes the spare code.
  localparam logic [3:0] LOAD      = 4'd0;
  localparam logic [3:0] ENC_XOR0  = 4'd1;
  localparam logic [3:0] ENC_SUB   = 4'd2;
  localparam logic [3:0] ENC_SHIFT = 4'd3;
  localparam logic [3:0] ENC_MIX   = 4'd4;
  localparam logic [3:0] ENC_KEY   = 4'd5;
  localparam logic [3:0] DEC_XOR0  = 4'd6;
  localparam logic [3:0] DEC_SHIFT = 4'd7;
  localparam logic [3:0] DEC_SUB   = 4'd8;
  localparam logic [3:0] DEC_KEY   = 4'd9;
  localparam logic [3:0] DEC_MIX   = 4'd10;
  localparam logic [3:0] OUT_DATA  = 4'd11;
  localparam logic [3:0] OUT_KEY   = 4'd12;
  localparam logic [3:0] FIN       = 4'd13;
  localparam logic [3:0] ERR       = 4'd14;
  localparam logic [3:0] IDLE      = 4'd15;

  localparam logic [1:0] MODE_ENC = 2'b01;
  localparam logic [1:0] MODE_DEC = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ROUNDS = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_ROUNDS - 1);

  logic [3:0]       state_q, state_nxt;
  logic [1:0]       mode_q, mode_nxt;
  logic [CNT_W-1:0] round_q, round_nxt;
  logic [CNT_W-1:0] round_inc, round_dec;
  logic             last_round;

  assign round_inc = round_q + CNT_ONE;
  assign round_dec = round_q - CNT_ONE;

  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    round_nxt = round_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_nxt = LOAD;
        mode_nxt  = mode;
      end
    end else if (abort) begin
      state_nxt = IDLE;
      round_nxt = CNT_ZERO;
    end else if (!stall) begin
      case (state_q)
        LOAD: begin
          if (mode_q == MODE_ENC)      state_nxt = ENC_XOR0;
          else if (mode_q == MODE_DEC) state_nxt = DEC_XOR0;
          else                         state_nxt = ERR;
        end
        ENC_XOR0: begin
          round_nxt = CNT_ZERO;
          state_nxt = ENC_SUB;
        end
        ENC_SUB:   state_nxt = ENC_SHIFT;
        ENC_SHIFT: state_nxt = (round_q < CNT_LAST) ? ENC_MIX : ENC_KEY;
        ENC_MIX:   state_nxt = ENC_KEY;
        ENC_KEY: begin
          round_nxt = round_inc;
          state_nxt = (round_inc < CNT_ROUNDS) ? ENC_SUB : OUT_DATA;
        end
        DEC_XOR0: begin
          round_nxt = CNT_ROUNDS;
          state_nxt = DEC_SHIFT;
        end
        DEC_SHIFT: state_nxt = DEC_SUB;
        DEC_SUB:   state_nxt = DEC_KEY;
        DEC_KEY: begin
          round_nxt = round_dec;
          state_nxt = (round_dec > CNT_ZERO) ? DEC_MIX : OUT_DATA;
        end
        DEC_MIX:  state_nxt = DEC_SHIFT;
        OUT_DATA: state_nxt = OUT_KEY;
        OUT_KEY:  state_nxt = FIN;
        FIN:      state_nxt = IDLE;
        ERR:      state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      round_q <= CNT_ZERO;
    end else begin
      state_q <= state_nxt;
      mode_q  <= mode_nxt;
      round_q <= round_nxt;
    end
  end

  // The final round has no mix-column, so only SUB/SHIFT/KEY carry the flag.
  always_comb begin
    last_round = 1'b0;
    case (state_q)
      ENC_SUB, ENC_SHIFT, ENC_KEY: last_round = (round_q == CNT_LAST);
      DEC_SHIFT, DEC_SUB, DEC_KEY: last_round = (round_q == CNT_ONE);
      default:                     last_round = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = 16'h0000;
    if (!stall) begin
      if (state_q != IDLE) ctrl[state_q] = 1'b1;
      ctrl[15] = last_round;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign done  = ctrl[FIN];
  assign err   = ctrl[ERR];
  assign round = round_q;

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Scoreboard bench for crypto_round_sequencer: expected per-cycle ctrl/round
// entries are queued when an operation starts and compared as the DUT steps.
module tb_crypto_round_sequencer;

  typedef struct packed {
    logic [15:0] c;
    logic [2:0]  r;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start6;
  logic [1:0]  mode;
  logic        stall;
  logic        abort;
  logic        ready, busy, done, err;
  logic [2:0]  round;
  logic [15:0] ctrl;
  logic        ready6, busy6, done6, err6;
  logic [2:0]  round6;
  logic [15:0] ctrl6;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [2:0] model_round;

  crypto_round_sequencer #(.NUM_ROUNDS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall), .abort(abort),
    .ready(ready), .busy(busy), .done(done), .err(err), .round(round), .ctrl(ctrl)
  );

  crypto_round_sequencer #(.NUM_ROUNDS(6), .CNT_W(3)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .mode(mode), .stall(stall), .abort(abort),
    .ready(ready6), .busy(busy6), .done(done6), .err(err6), .round(round6), .ctrl(ctrl6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] c);
    exp_t e;
    e.c = c;
    e.r = model_round;
    q.push_back(e);
  endtask

  // Expected strobe sequence for one operation, built from the round schedule.
  task automatic gen(input logic [1:0] m, input int nr);
    logic [15:0] lf;
    push(16'h0001);
    if (m == 2'b01) begin
      push(16'h0002);
      model_round = 3'd0;
      for (int i = 0; i < nr; i++) begin
        lf = (i == nr - 1) ? 16'h8000 : 16'h0000;
        push(16'h0004 | lf);
        push(16'h0008 | lf);
        if (i != nr - 1) push(16'h0010);
        push(16'h0020 | lf);
        model_round = model_round + 3'd1;
      end
    end else if (m == 2'b10) begin
      push(16'h0040);
      model_round = 3'(nr);
      for (int i = nr; i >= 1; i--) begin
        lf = (i == 1) ? 16'h8000 : 16'h0000;
        push(16'h0080 | lf);
        push(16'h0100 | lf);
        push(16'h0200 | lf);
        model_round = model_round - 3'd1;
        if (i != 1) push(16'h0400);
      end
    end else begin
      push(16'h4000);
      return;
    end
    push(16'h0800);
    push(16'h1000);
    push(16'h2000);
  endtask

  task automatic do_op(input logic [1:0] m, input int exp_cycles, input bit stall_mix,
                       input bit abort_sh, input int reset_at, input bit abort_start);
    exp_t e;
    int   cycles;
    int   stalls;
    bit   stop;
    bit   aborted;
    q.delete();
    gen(m, 4);
    @(posedge clk); #1;
    start = 1'b1; mode = m; abort = abort_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; mode = 2'b00;
    cycles = 0; stalls = 0; stop = 1'b0; aborted = 1'b0;
    while (q.size() > 0 && !stop && cycles < 200) begin
      e = q[0];
      if (cycles == reset_at) begin
        rst = 1'b0;
        #1;
        check("rst_ctrl", ctrl, 16'h0000);
        check("rst_ready", ready, 1);
        check("rst_round", round, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        model_round = 3'd0;
        stop = 1'b1;
      end else begin
        stall = 1'b0;
        if (stall_mix && e.c[4] && stalls < 3) begin
          stall = 1'b1;
          stalls++;
        end
        if (abort_sh && e.c[3] && e.r == 3'd2) begin
          stall = 1'b1;
          abort = 1'b1;
        end
        @(negedge clk);
        if (stall) begin
          check("stall_ctrl", ctrl, 16'h0000);
          check("stall_round", round, e.r);
          check("stall_busy", busy, 1);
          check("stall_done", done, 0);
        end else begin
          check("ctrl", ctrl, e.c);
          check("round", round, e.r);
          check("busy", busy, 1);
          check("ready", ready, 0);
          check("done", done, e.c[13]);
          check("err", err, e.c[14]);
        end
        if (abort) begin
          aborted = 1'b1;
          stop = 1'b1;
          q.delete();
          model_round = 3'd0;
        end else if (!stall) begin
          void'(q.pop_front());
        end
        cycles++;
        @(posedge clk); #1;
        stall = 1'b0;
        abort = 1'b0;
      end
    end
    if (!stop) check("drained", q.size(), 0);
    if (reset_at < 0) begin
      @(negedge clk);
      check("ready_after", ready, 1);
      check("done_after", done, 0);
      if (aborted) check("abort_round", round, 0);
      else         check("latency", cycles, exp_cycles);
    end
  endtask

  initial begin
    int n6;
    int dn6;
    rst = 1'b0; start = 1'b0; start6 = 1'b0; mode = 2'b00; stall = 1'b0; abort = 1'b0;
    model_round = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_ctrl", ctrl, 16'h0000);
    check("reset_round", round, 0);
    rst = 1'b1;

    do_op(2'b01, 20, 1'b0, 1'b0, -1, 1'b0);
    do_op(2'b10, 20, 1'b0, 1'b0, -1, 1'b0);
    do_op(2'b00, 2, 1'b0, 1'b0, -1, 1'b0);
    do_op(2'b11, 2, 1'b0, 1'b0, -1, 1'b0);
    do_op(2'b01, 23, 1'b1, 1'b0, -1, 1'b0);
    do_op(2'b01, 0, 1'b0, 1'b1, -1, 1'b0);
    do_op(2'b10, 20, 1'b0, 1'b0, -1, 1'b0);
    do_op(2'b10, 0, 1'b0, 1'b0, 7, 1'b0);
    do_op(2'b01, 20, 1'b0, 1'b0, -1, 1'b1);

    @(posedge clk); #1;
    start6 = 1'b1; mode = 2'b01;
    @(posedge clk); #1;
    start6 = 1'b0; mode = 2'b00;
    n6 = 0; dn6 = 0;
    do begin
      @(negedge clk);
      if (busy6) n6++;
      if (done6) dn6++;
    end while (busy6 && n6 < 100);
    check("lat6", n6, 28);
    check("done6", dn6, 1);
    check("round6", round6, 6);
    check("ready6", ready6, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
